// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: time-multiplexes NUM_DIGITS active-low patterns
// onto one shared segment bus with one-hot active-low digit enables and anti-ghost blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_DIGITS*7-1:0] seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [2:0]              cur_digit,
  output logic                    frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_DIG   = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  function automatic logic [6:0] pick_pattern(input logic [NUM_DIGITS*7-1:0] s,
                                              input logic [2:0] idx);
    logic [6:0] r;
    r = SEG_OFF;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == 3'(i)) r = s[7*i +: 7];
    return r;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] enable_for(input logic [2:0] idx);
    logic [NUM_DIGITS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == 3'(i)) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [2:0] next_digit(input logic [2:0] idx);
    return (idx == LAST_DIG) ? 3'd0 : idx + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_digit  <= 3'd0;
      seg_out    <= SEG_OFF;
      dig_en     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        // Disabling always collapses to IDLE so re-enable restarts at digit 0.
        state     <= IDLE;
        cnt       <= '0;
        cur_digit <= 3'd0;
        seg_out   <= SEG_OFF;
        dig_en    <= '1;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (BLANK_CYCLES == 0) begin
              state   <= SHOW;
              seg_out <= pick_pattern(seg_in, 3'd0);
              dig_en  <= enable_for(3'd0);
            end else begin
              state <= BLANK;
            end
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state   <= SHOW;
              cnt     <= '0;
              seg_out <= pick_pattern(seg_in, cur_digit);
              dig_en  <= enable_for(cur_digit);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (cnt == DWELL_LAST) begin
              cnt        <= '0;
              cur_digit  <= next_digit(cur_digit);
              frame_done <= (cur_digit == LAST_DIG);
              // Without blanking the enable and the new snapshot switch on the same edge.
              if (BLANK_CYCLES == 0) begin
                seg_out <= pick_pattern(seg_in, next_digit(cur_digit));
                dig_en  <= enable_for(next_digit(cur_digit));
              end else begin
                state   <= BLANK;
                seg_out <= SEG_OFF;
                dig_en  <= '1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            seg_out <= SEG_OFF;
            dig_en  <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the board's seven-segment displays. It takes NUM_DIGITS active-low segment patterns from the display decoders (tens/ones for out0..out2) and drives one shared 7-bit segment bus plus one-hot active-low digit enables. It inserts a blanking interval between digits to prevent ghosting. It sits between the display decoders and the FPGA pins.

Parameters:
NUM_DIGITS, 6, number of digits scanned (2..8)
DWELL_CYCLES, 1000, cycles each digit is lit (>=1)
BLANK_CYCLES, 16, all-off cycles between digits (>=0; 0 disables blanking)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
en  input  1  scan enable; low forces blank/idle
seg_in  input  NUM_DIGITS*7  active-low patterns; digit i at [7i+6:7i]
seg_out  output  7  shared active-low segment bus
dig_en  output  NUM_DIGITS  active-low one-hot digit enables
cur_digit  output  3  index of the digit currently selected/next to light
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs are flops, with no combinational decode to pins.
- Reset (rst=0, immediate, no clock needed): state=IDLE, seg_out=7'h7F, dig_en=all ones, cur_digit=0, frame_done=0, counters=0.
- FSM states: IDLE, BLANK, SHOW. A single down/up counter (width sized for max(DWELL,BLANK)) times each state.
- IDLE: outputs blank, cur_digit=0. If en=1 at an edge, go to BLANK with cnt=0 (or straight to SHOW if BLANK_CYCLES=0).
- BLANK: seg_out=7F, dig_en=all ones, held exactly BLANK_CYCLES cycles. At the exit edge:
  - snapshot seg_in slice cur_digit into the seg_out register;
  - drive dig_en[cur_digit]=0;
  - go to SHOW.
- SHOW: outputs held exactly DWELL_CYCLES cycles. The snapshot is stable; seg_in changes during the dwell are ignored. At the exit edge:
  - outputs blank;
  - cur_digit increments, wrapping NUM_DIGITS-1 -> 0;
  - go to BLANK.
- BLANK_CYCLES=0: SHOW -> SHOW directly. At the edge, dig_en moves to the next digit and seg_out takes the new snapshot together.
- frame_done: 1 for exactly the cycle after the exit edge of SHOW for digit NUM_DIGITS-1. Otherwise 0.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- en=0 sampled at any edge in BLANK/SHOW: next cycle is IDLE, blank, cur_digit=0, frame_done=0, cnt=0. Re-enabling always restarts from digit 0 with a full BLANK.
- Invariant: at most one dig_en bit is low in any cycle. dig_en is never low while seg_out is blanked by IDLE/BLANK.
- Reset mid-SHOW: outputs blank asynchronously. After release, behaviour is identical to a fresh reset.

Test Plan:
- Reset: assert rst=0 between edges while digit 2 is lit -> seg_out=7F, dig_en=3F, cur_digit=0, frame_done=0 before the next edge.
- Basic scan (DWELL=4, BLANK=2, digit i pattern = 7'h40|i), en=1 at edge 0:
  - 2 blank cycles, then dig_en=111110 with seg_out=40 for 4 cycles;
  - 2 blank cycles, then dig_en=111101 with seg_out=41;
  - ... through digit 5;
  - frame_done pulses once per 36 cycles, cur_digit wraps 5 -> 0.
- Snapshot hold: change digit 1 pattern 41 -> 7E during its 2nd dwell cycle -> seg_out stays 41 for the dwell; 7E appears on digit 1's next frame.
- Disable mid-dwell: en=0 during SHOW of digit 3 -> next cycle all blank, cur_digit=0. en=1 again -> 2 blank cycles, then digit 0 lit.
- BLANK_CYCLES=0 instance: continuous scan with no blank cycles; every cycle has exactly one dig_en bit low; frame_done every 24 cycles.
- Scoreboard across 3 frames: checker asserts one-hot-or-none dig_en every cycle and exact per-digit dwell counts.
